data_ram_ctrl: RTL and testbench

//   Data-memory responder on the far side of the pipeline's load/store port.

---
 rtl/data_ram_ctrl.sv | 129 ++++++++++++
 tb/tb_data_ram_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: single-outstanding data-memory responder for the mem stage.
// A request is captured in IDLE, waits WAIT_CYCLES cycles, and completes
// with a one-cycle ack. The array access itself occurs on the edge that
// enters RESP, so the read word is already registered during the ack cycle.
module data_ram_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [3:0]            sel_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o,
  output logic                  stallreq_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         NUM_LANES = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  logic                  w_enter_resp;
  logic                  w_acc_we;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [3:0]            w_acc_sel;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic                  w_unused_addr;

  // Byte offset and aliasing bits of the address never reach the array.
  assign w_unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // With zero wait states the access edge is also the capture edge, so the
  // access must use the live inputs instead of the request registers.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_sel   = r_sel;
    w_acc_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_acc_we    = we_i;
      w_acc_addr  = addr_i[ADDR_WIDTH+1:2];
      w_acc_sel   = sel_i;
      w_acc_wdata = data_i;
    end
  end

  // Access edge; a reset on this edge drops an uncommitted write.
  assign w_enter_resp = !rst &&
                        (((r_state == S_IDLE) && ce_i && (WAIT_CYCLES == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  // Request FSM: capture in IDLE, count wait states, one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= 4'd0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ce_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i[ADDR_WIDTH+1:2];
            r_sel   <= sel_i;
            r_wdata <= data_i;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word array with per-lane write enables and a registered read port.
  always_ff @(posedge clk) begin
    if (w_enter_resp) begin
      if (w_acc_we) begin
        for (int li = 0; li < NUM_LANES; li++) begin
          if (w_acc_sel[li]) begin
            r_mem[w_acc_addr][8*li +: 8] <= w_acc_wdata[8*li +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[w_acc_addr];
      end
    end
  end

  // Outputs decoded from the state register; read data is gated to read acks.
  always_comb begin
    ack_o      = (r_state == S_RESP);
    data_o     = ((r_state == S_RESP) && !r_we) ? r_rdata : '0;
    stallreq_o = ((r_state == S_IDLE) && ce_i) || (r_state == S_WAIT);
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Testbench for data_ram_ctrl: directed table, corner sequences, random traffic.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce2, ce0;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] data2, data0;
  logic        ack2, ack0, stall2, stall0;

  int errors = 0;
  int checks = 0;

  // Reference memory contents per instance (0: WAIT_CYCLES=2, 1: WAIT_CYCLES=0)
  logic [31:0] model [2][1024];

  always #5 clk = ~clk;

  data_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ce_i(ce2), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(data2), .ack_o(ack2), .stallreq_o(stall2)
  );

  data_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(data0), .ack_o(ack0), .stallreq_o(stall0)
  );

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: words alias modulo 4 KiB, only enabled bytes change.
  function automatic logic [31:0] model_exp(input int inst, input logic w, input logic [31:0] a);
    if (w) return 32'h0;
    return model[inst][a[11:2]];
  endfunction

  task automatic model_write(input int inst, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] word;
    word = model[inst][a[11:2]];
    for (int b = 0; b < 4; b++)
      if (s[b]) word[8*b +: 8] = d[8*b +: 8];
    model[inst][a[11:2]] = word;
  endtask

  // One transaction; checks stall each cycle, latency 1+WAIT_CYCLES, and ack data.
  task automatic do_req(input int inst, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input string name);
    int          wc;
    bit          done;
    logic        a_ack, a_stall;
    logic [31:0] a_data, exp;
    wc  = (inst == 1) ? 0 : 2;
    exp = model_exp(inst, w, a);
    @(posedge clk); #1;
    we = w; addr = a; sel = s; wdata = d;
    if (inst == 1) ce0 = 1'b1; else ce2 = 1'b1;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      a_ack   = (inst == 1) ? ack0 : ack2;
      a_stall = (inst == 1) ? stall0 : stall2;
      a_data  = (inst == 1) ? data0 : data2;
      if (a_ack) begin
        check(k == 1 + wc, {name, " latency"}, 32'(k), 32'(1 + wc));
        check(a_stall == 1'b0, {name, " stall_at_ack"}, 32'(a_stall), 32'h0);
        check(a_data == exp, {name, " data"}, a_data, exp);
        $display("%s inst=%0d we=%0b addr=%h sel=%h data_o=%h lat=%0d", name, inst, w, a, s, a_data, k);
        done = 1;
      end else begin
        check(a_stall == 1'b1, {name, " stall_wait"}, 32'(a_stall), 32'h1);
      end
    end
    if (!done) check(1'b0, {name, " ack_timeout"}, 32'h0, 32'h1);
    ce0 = 1'b0; ce2 = 1'b0;
    if (w) model_write(inst, a, s, d);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int acks;
    logic [31:0] got [2];

    vecs[0] = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h10,   4'h1, 32'h000000AA, 32'h0};
    vecs[3] = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEAA};
    vecs[4] = '{1'b1, 32'h10,   4'h0, 32'h00000055, 32'h0};
    vecs[5] = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEAA};
    vecs[6] = '{1'b1, 32'h1004, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b0, 32'h0004, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[8] = '{1'b0, 32'h0006, 4'hF, 32'h0,        32'hCAFEF00D};

    rst = 1'b1; ce2 = 0; ce0 = 0; we = 0; addr = 0; sel = 0; wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(ack2 == 1'b0, "reset ack", 32'(ack2), 32'h0);
    check(data2 == 32'h0, "reset data", data2, 32'h0);
    check(stall2 == 1'b0, "reset stall", 32'(stall2), 32'h0);
    check(ack0 == 1'b0, "reset ack0", 32'(ack0), 32'h0);
    rst = 1'b0;

    // Define the first 16 words of both arrays so every later read is known.
    for (int inst = 0; inst < 2; inst++)
      for (int i = 0; i < 16; i++)
        do_req(inst, 1'b1, 32'(i * 4), 4'hF, $urandom, "init");

    // Directed table: full word, byte lane, sel=0, aliasing (both wait settings).
    for (int inst = 0; inst < 2; inst++)
      for (int i = 0; i < 9; i++) begin
        check(model_exp(inst, vecs[i].we, vecs[i].addr) == vecs[i].exp || vecs[i].we,
              "table_model", model_exp(inst, vecs[i].we, vecs[i].addr), vecs[i].exp);
        do_req(inst, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, "table");
      end

    // Reset during the first WAIT cycle abandons the pending write.
    @(posedge clk); #1;
    we = 1; addr = 32'h10; sel = 4'hF; wdata = 32'h12345678; ce2 = 1;
    @(posedge clk); #1;
    rst = 1; ce2 = 0;
    @(posedge clk);
    @(negedge clk);
    check(ack2 == 1'b0, "rst_mid ack", 32'(ack2), 32'h0);
    check(stall2 == 1'b0, "rst_mid stall", 32'(stall2), 32'h0);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      check(ack2 == 1'b0, "rst_mid no_ack", 32'(ack2), 32'h0);
    end
    do_req(0, 1'b0, 32'h10, 4'hF, 32'h0, "rst_mid read");

    // Back-to-back reads with ce held high: two acks, one per transaction.
    acks = 0;
    @(posedge clk); #1;
    we = 0; addr = 32'h0; sel = 4'hF; ce2 = 1;
    for (int k = 0; k < 30 && acks < 2; k++) begin
      @(negedge clk);
      if (ack2) begin
        got[acks] = data2;
        acks++;
        addr = 32'h4;
        if (acks == 2) ce2 = 0;
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (ack2) acks++;
    end
    check(acks == 2, "b2b ack_count", 32'(acks), 32'h2);
    check(got[0] == model[0][0], "b2b data0", got[0], model[0][0]);
    check(got[1] == model[0][1], "b2b data1", got[1], model[0][1]);
    $display("b2b acks=%0d d0=%h d1=%h", acks, got[0], got[1]);

    // Random traffic over 16 words with random aliasing and byte offsets.
    for (int i = 0; i < 120; i++) begin
      int          inst;
      logic [31:0] a;
      inst = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      do_req(inst, 1'($urandom), a, 4'($urandom), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
